reset_seq_ctrl: RTL

Staged reset release sequencer that sits downstream of the fabric reset synchroniser (CORERESET_PF). It waits for the synchronised FABRIC_RESET_N and PLL_LOCK to be stable, then releases a chain of per-subsystem resets one stage at a time. For example, the chain could run bus, then memory, then CPU core. Before releasing the next stage, it waits for each stage to report ready. It re-asserts every stage reset on loss of fabric reset or PLL lock, on a software reset request, or on a stage timeout.

---
 rtl/reset_seq_pkg.sv | 25 ++
 rtl/reset_seq_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and helpers for the staged reset release sequencer.
//   seq_state_e  : FSM state encoding, also driven onto SEQ_STATE for debug.
//   cnt_width()  : width of the shared hold/timeout counter.
// -----------------------------------------------------------------------------
package reset_seq_pkg;

   typedef enum logic [2:0] {
      StHold    = 3'd0,
      StRelease = 3'd1,
      StWait    = 3'd2,
      StRun     = 3'd3,
      StError   = 3'd4
   } seq_state_e;

   // The counter must hold values up to max(hold, timeout) - 1; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                             input int unsigned timeout_cycles);
      int unsigned m;
      m = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/reset_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reset_seq_ctrl
// Staged reset release sequencer. Waits for FABRIC_RESET_N and PLL_LOCK to be
// stable for HOLD_CYCLES, then releases per-stage resets one at a time, waiting
// for each stage's ready before moving on. Any loss of fabric reset / PLL lock
// or a software request re-asserts all stage resets; a stage that never reports
// ready parks the sequencer in ERROR.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   FABRIC_RESET_N   synchronised fabric reset (active low)
//   PLL_LOCK         synchronised PLL lock
//   SW_RST_REQ       software reset request (level)
//   STAGE_READY      per-stage ready
//   STAGE_RESET_N    per-stage active-low reset (registered)
//   SEQ_DONE         all stages released and ready (registered)
//   SEQ_ERROR        stage timeout occurred (registered)
//   SEQ_STATE        current FSM state (debug)
// -----------------------------------------------------------------------------
module reset_seq_ctrl
   import reset_seq_pkg::*;
#(
   parameter int unsigned N_STAGES       = 3,
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                FABRIC_RESET_N,
   input  logic                PLL_LOCK,
   input  logic                SW_RST_REQ,
   input  logic [N_STAGES-1:0] STAGE_READY,
   output logic [N_STAGES-1:0] STAGE_RESET_N,
   output logic                SEQ_DONE,
   output logic                SEQ_ERROR,
   output logic [2:0]          SEQ_STATE
);

   localparam int unsigned CntW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam int unsigned IdxW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [IdxW-1:0] IdxLast     = IdxW'(N_STAGES - 1);

   seq_state_e          state_q;
   logic [IdxW-1:0]     idx_q;
   logic [CntW-1:0]     cnt_q;
   logic [N_STAGES-1:0] stage_reset_n_q;
   logic                done_q;
   logic                error_q;

   logic            ok;
   logic [IdxW-1:0] idx_inc;

   assign ok      = FABRIC_RESET_N & PLL_LOCK & ~SW_RST_REQ;
   assign idx_inc = idx_q + IdxW'(1);

   // One shared counter: hold-stability count in HOLD, ready timeout in WAIT.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q         <= StHold;
         idx_q           <= '0;
         cnt_q           <= '0;
         stage_reset_n_q <= '0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else if (state_q != StError && !ok) begin
         // Abort outranks ready and timeout, including the final stage's ready.
         state_q         <= StHold;
         idx_q           <= '0;
         cnt_q           <= '0;
         stage_reset_n_q <= '0;
         done_q          <= 1'b0;
      end else begin
         unique case (state_q)
            StHold: begin
               if (cnt_q == HoldLast) begin
                  state_q            <= StRelease;
                  idx_q              <= '0;
                  stage_reset_n_q[0] <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StRelease: begin
               cnt_q   <= '0;
               state_q <= StWait;
            end
            StWait: begin
               // Ready beats a timeout landing on the same edge.
               if (STAGE_READY[idx_q]) begin
                  if (idx_q == IdxLast) begin
                     state_q <= StRun;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q                    <= idx_inc;
                     stage_reset_n_q[idx_inc] <= 1'b1;
                     state_q                  <= StRelease;
                  end
               end else if (cnt_q == TimeoutLast) begin
                  state_q         <= StError;
                  stage_reset_n_q <= '0;
                  error_q         <= 1'b1;
                  idx_q           <= '0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StRun: begin
               state_q <= StRun;
            end
            StError: begin
               // PLL lock alone cannot clear an error; needs software or fabric reset.
               if (SW_RST_REQ || !FABRIC_RESET_N) begin
                  state_q <= StHold;
                  error_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= StHold;
            end
         endcase
      end
   end

   assign STAGE_RESET_N = stage_reset_n_q;
   assign SEQ_DONE      = done_q;
   assign SEQ_ERROR     = error_q;
   assign SEQ_STATE     = state_q;

endmodule
